// File: rtl/dot_scheduler.sv
// dot_scheduler: arbitrates two digit requesters onto one dot-matrix display.
// Each grant lights the display for HOLD_CYCLES, then blanks for GAP_CYCLES.
// Ties in IDLE are resolved round-robin against the last granted requester.
module dot_scheduler #(
    parameter int unsigned HOLD_CYCLES = 24000000,
    parameter int unsigned GAP_CYCLES  = 6000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic [3:0] DIGIT_A,
    input  logic [3:0] DIGIT_B,
    input  logic       CLEAR,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       ERR_A,
    output logic       ERR_B,
    output logic [3:0] DOT_DIGIT,
    output logic       DOT_EN,
    output logic [1:0] OWNER,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0]  OWN_NONE  = 2'b00;
    localparam logic [1:0]  OWN_A     = 2'b01;
    localparam logic [1:0]  OWN_B     = 2'b10;
    localparam logic [24:0] HOLD_LAST = 25'(HOLD_CYCLES - 1);
    localparam logic [24:0] GAP_LAST  = 25'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [3:0]  digit_q, digit_d;
    logic        en_q, en_d;
    logic [1:0]  owner_q, owner_d;
    logic        busy_q, busy_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic        err_a_q, err_a_d;
    logic        err_b_q, err_b_d;
    logic        last_b_q, last_b_d;

    logic elig_a, elig_b, bad_a, bad_b, pick_a, pick_b;

    // Eligibility and round-robin pick among the two requesters
    always_comb begin
        elig_a = REQ_A && (DIGIT_A <= 4'd9);
        elig_b = REQ_B && (DIGIT_B <= 4'd9);
        bad_a  = REQ_A && (DIGIT_A > 4'd9);
        bad_b  = REQ_B && (DIGIT_B > 4'd9);
        pick_a = elig_a && (!elig_b || last_b_q);
        pick_b = elig_b && !pick_a;
    end

    // State and registered outputs; reset leaves LAST=B so A wins the first tie
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digit_q  <= '0;
            en_q     <= 1'b0;
            owner_q  <= OWN_NONE;
            busy_q   <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            err_a_q  <= 1'b0;
            err_b_q  <= 1'b0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            en_q     <= en_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            err_a_q  <= err_a_d;
            err_b_q  <= err_b_d;
            last_b_q <= last_b_d;
        end
    end

    // Next state and shared SHOW/GAP counter; CLEAR overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (CLEAR) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_a || pick_b) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end
                end
                SHOW: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 25'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 25'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs and the round-robin pointer
    always_comb begin
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        err_a_d  = 1'b0;
        err_b_d  = 1'b0;
        digit_d  = digit_q;
        en_d     = en_q;
        owner_d  = owner_q;
        last_b_d = last_b_q;
        busy_d   = (state_d != IDLE);
        if (CLEAR) begin
            digit_d = '0;
            en_d    = 1'b0;
            owner_d = OWN_NONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    err_a_d = bad_a;
                    err_b_d = bad_b;
                    if (pick_a) begin
                        gnt_a_d  = 1'b1;
                        digit_d  = DIGIT_A;
                        en_d     = 1'b1;
                        owner_d  = OWN_A;
                        last_b_d = 1'b0;
                    end else if (pick_b) begin
                        gnt_b_d  = 1'b1;
                        digit_d  = DIGIT_B;
                        en_d     = 1'b1;
                        owner_d  = OWN_B;
                        last_b_d = 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == HOLD_LAST) begin
                        digit_d = '0;
                        en_d    = 1'b0;
                        owner_d = OWN_NONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign GNT_A     = gnt_a_q;
    assign GNT_B     = gnt_b_q;
    assign ERR_A     = err_a_q;
    assign ERR_B     = err_b_q;
    assign DOT_DIGIT = digit_q;
    assign DOT_EN    = en_q;
    assign OWNER     = owner_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_dot_scheduler.sv
// Self-checking bench for dot_scheduler with HOLD_CYCLES=8, GAP_CYCLES=2.
module tb_dot_scheduler;

    localparam int unsigned HOLD = 8;
    localparam int unsigned GAPC = 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ_A, REQ_B, CLEAR;
    logic [3:0] DIGIT_A, DIGIT_B;
    logic       GNT_A, GNT_B, ERR_A, ERR_B, DOT_EN, BUSY;
    logic [3:0] DOT_DIGIT;
    logic [1:0] OWNER;

    dot_scheduler #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .DIGIT_A(DIGIT_A), .DIGIT_B(DIGIT_B),
        .CLEAR(CLEAR),
        .GNT_A(GNT_A), .GNT_B(GNT_B),
        .ERR_A(ERR_A), .ERR_B(ERR_B),
        .DOT_DIGIT(DOT_DIGIT), .DOT_EN(DOT_EN),
        .OWNER(OWNER), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sb_on  = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] own;
        logic [3:0] dig;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       ra;
        logic [3:0] da;
        logic       rb;
        logic [3:0] db;
        logic       ga, gb, ea, eb;
        logic [3:0] dig;
        logic       en;
        logic [1:0] own;
        logic       busy;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_grant(input logic [1:0] own, input logic [3:0] dig, input int at);
        exp_t e;
        e.own = own;
        e.dig = dig;
        e.cyc = at;
        sb_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'({GNT_B, GNT_A}), 32'd0);
        check({tag, "_err"},   32'({ERR_B, ERR_A}), 32'd0);
        check({tag, "_digit"}, 32'(DOT_DIGIT), 32'd0);
        check({tag, "_en"},    32'(DOT_EN), 32'd0);
        check({tag, "_owner"}, 32'(OWNER), 32'd0);
        check({tag, "_busy"},  32'(BUSY), 32'd0);
    endtask

    // Reset pulse, released on a falling edge; returns just after that edge
    task automatic do_reset();
        RESET   = 1'b1;
        REQ_A   = 1'b0;
        REQ_B   = 1'b0;
        CLEAR   = 1'b0;
        DIGIT_A = 4'd0;
        DIGIT_B = 4'd0;
        #12;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic check_drain(input string tag);
        check({tag, "_sb_drain"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Grant monitor: every observed grant must match the next queued expectation
    always @(negedge CLK) begin
        if (sb_on && (GNT_A || GNT_B)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_grant: got gnt=%b%b expected none (cyc=%0d)", GNT_B, GNT_A, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_gnt_pair", 32'({GNT_B, GNT_A}), 32'(e.own));
                check("sb_owner",    32'(OWNER), 32'(e.own));
                check("sb_digit",    32'(DOT_DIGIT), 32'(e.dig));
                check("sb_cycle",    32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        //          ra   da    rb   db     ga gb ea eb  dig  en own busy
        vecs[0] = '{1'b1, 4'd5,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 2'd1, 1'b1};
        vecs[1] = '{1'b0, 4'd0,  1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 2'd2, 1'b1};
        vecs[2] = '{1'b1, 4'd1,  1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 2'd1, 1'b1};
        vecs[3] = '{1'b0, 4'd0,  1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0};
        vecs[4] = '{1'b1, 4'd3,  1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 2'd1, 1'b1};
        vecs[5] = '{1'b1, 4'd10, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0};
        vecs[6] = '{1'b1, 4'd9,  1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 2'd1, 1'b1};
        vecs[7] = '{1'b1, 4'd15, 1'b1, 4'd9,  1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 2'd2, 1'b1};
        vecs[8] = '{1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0};

        // Reset values
        RESET   = 1'b1;
        REQ_A   = 1'b0;
        REQ_B   = 1'b0;
        CLEAR   = 1'b0;
        DIGIT_A = 4'd0;
        DIGIT_B = 4'd0;
        #22;
        check_reset_outputs("reset");

        // Single-edge IDLE decisions from a fresh reset
        for (int i = 0; i < 9; i++) begin
            do_reset();
            REQ_A   = vecs[i].ra;
            DIGIT_A = vecs[i].da;
            REQ_B   = vecs[i].rb;
            DIGIT_B = vecs[i].db;
            tick();
            check($sformatf("vec%0d_gnt_a", i), 32'(GNT_A), 32'(vecs[i].ga));
            check($sformatf("vec%0d_gnt_b", i), 32'(GNT_B), 32'(vecs[i].gb));
            check($sformatf("vec%0d_err_a", i), 32'(ERR_A), 32'(vecs[i].ea));
            check($sformatf("vec%0d_err_b", i), 32'(ERR_B), 32'(vecs[i].eb));
            check($sformatf("vec%0d_digit", i), 32'(DOT_DIGIT), 32'(vecs[i].dig));
            check($sformatf("vec%0d_en", i),    32'(DOT_EN), 32'(vecs[i].en));
            check($sformatf("vec%0d_owner", i), 32'(OWNER), 32'(vecs[i].own));
            check($sformatf("vec%0d_busy", i),  32'(BUSY), 32'(vecs[i].busy));
        end

        sb_on = 1'b1;

        // Single A grant: 8 lit cycles, 2 blank, busy for 10
        do_reset();
        REQ_A   = 1'b1;
        DIGIT_A = 4'd5;
        push_grant(2'b01, 4'd5, cyc + 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            REQ_A = 1'b0;
            check($sformatf("hold_en_%0d", i),    32'(DOT_EN), 32'(i < 8));
            check($sformatf("hold_digit_%0d", i), 32'(DOT_DIGIT), (i < 8) ? 32'd5 : 32'd0);
            check($sformatf("hold_busy_%0d", i),  32'(BUSY), 32'(i < 10));
            check($sformatf("hold_owner_%0d", i), 32'(OWNER), (i < 8) ? 32'd1 : 32'd0);
        end
        check_drain("hold");

        // Both held: alternating grants 11 cycles apart
        do_reset();
        REQ_A   = 1'b1;
        REQ_B   = 1'b1;
        DIGIT_A = 4'd1;
        DIGIT_B = 4'd2;
        begin
            int c0;
            c0 = cyc + 1;
            push_grant(2'b01, 4'd1, c0);
            push_grant(2'b10, 4'd2, c0 + 11);
            push_grant(2'b01, 4'd1, c0 + 22);
            push_grant(2'b10, 4'd2, c0 + 33);
        end
        for (int i = 0; i < 36; i++) tick();
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check_drain("rr");

        // CLEAR at SHOW counter 4, held request re-granted on the next edge
        do_reset();
        REQ_A   = 1'b1;
        DIGIT_A = 4'd4;
        push_grant(2'b01, 4'd4, cyc + 1);
        for (int i = 0; i < 5; i++) tick();
        CLEAR = 1'b1;
        push_grant(2'b01, 4'd4, cyc + 2);
        tick();
        check("clr_en",    32'(DOT_EN), 32'd0);
        check("clr_owner", 32'(OWNER), 32'd0);
        check("clr_digit", 32'(DOT_DIGIT), 32'd0);
        check("clr_busy",  32'(BUSY), 32'd0);
        check("clr_gnt",   32'(GNT_A), 32'd0);
        CLEAR = 1'b0;
        tick();
        check("clr_regrant_en", 32'(DOT_EN), 32'd1);
        REQ_A = 1'b0;
        tick();
        check_drain("clr");

        // Reset in GAP: asynchronous return, then a tie goes to A again
        do_reset();
        REQ_A   = 1'b1;
        DIGIT_A = 4'd6;
        push_grant(2'b01, 4'd6, cyc + 1);
        tick();
        REQ_A = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("gap_busy_before_rst", 32'(BUSY), 32'd1);
        check("gap_en_before_rst",   32'(DOT_EN), 32'd0);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        check_drain("rst_gap");
        @(negedge CLK);
        RESET   = 1'b0;
        REQ_A   = 1'b1;
        REQ_B   = 1'b1;
        DIGIT_A = 4'd1;
        DIGIT_B = 4'd2;
        push_grant(2'b01, 4'd1, cyc + 1);
        tick();
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        tick();
        check_drain("rst_tie");

        // Digit change during SHOW does not disturb the captured digit
        do_reset();
        REQ_A   = 1'b1;
        DIGIT_A = 4'd7;
        push_grant(2'b01, 4'd7, cyc + 1);
        tick();
        REQ_A   = 1'b0;
        DIGIT_A = 4'd9;
        check("capt_digit_0", 32'(DOT_DIGIT), 32'd7);
        for (int i = 1; i < 9; i++) begin
            tick();
            check($sformatf("capt_digit_%0d", i), 32'(DOT_DIGIT), (i < 8) ? 32'd7 : 32'd0);
        end
        for (int i = 0; i < 3; i++) tick();
        check_drain("capt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_scheduler.md
DOT_SCHEDULER -- requirements
Module: dot_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 24000000, giving the display time per grant in CLK cycles (minimum 1).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 6000, giving the blank time after each display in CLK cycles (minimum 1).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports REQ_A/REQ_B, input, 1 bit each: display requests from requesters A and B, held high until granted.
REQ-006 The block SHALL have ports DIGIT_A/DIGIT_B, input, 4 bits each: digit to show, valid 0..9, sampled with the matching REQ.
REQ-007 The block SHALL have port CLEAR, input, 1 bit: synchronous abort of the current display.
REQ-008 The block SHALL have ports GNT_A/GNT_B, output, 1 bit each: one-cycle grant pulses.
REQ-009 The block SHALL have ports ERR_A/ERR_B, output, 1 bit each: one-cycle pulses reporting a rejected digit (>9).
REQ-010 The block SHALL have port DOT_DIGIT, output, 4 bits: digit code for the dot-matrix driver.
REQ-011 The block SHALL have port DOT_EN, output, 1 bit: the display is lit when high.
REQ-012 The block SHALL have port OWNER, output, 2 bits: 00 none, 01 A, 10 B.
REQ-013 The block SHALL have port BUSY, output, 1 bit: high when the FSM is not in IDLE.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 The FSM SHALL have states IDLE, SHOW and GAP, with one 25-bit cycle counter shared by SHOW and GAP.
REQ-016 In IDLE, a requester is eligible when its REQ=1 and its DIGIT<=9.
REQ-017 In IDLE with exactly one eligible requester, the block SHALL move to SHOW at that edge, capture its digit, pulse its GNT, and set DOT_EN=1, OWNER to that requester, and counter=0.
REQ-018 In IDLE with both requesters eligible, the block SHALL grant round-robin: the requester not equal to LAST wins; LAST updates on every grant.
REQ-019 In IDLE, REQ=1 with DIGIT>9 SHALL pulse that requester's ERR for one cycle on every such IDLE edge, with no grant; the other requester may still be granted in the same cycle.
REQ-020 In SHOW, DOT_EN SHALL stay high for exactly HOLD_CYCLES cycles; at the edge where counter==HOLD_CYCLES-1 the block SHALL enter GAP with DOT_EN=0, OWNER=00, DOT_DIGIT=0 and counter=0.
REQ-021 In GAP, the block SHALL remain for exactly GAP_CYCLES cycles, then enter IDLE.
REQ-022 Requests in SHOW or GAP SHALL be neither granted nor errored; they are evaluated on the first IDLE cycle.
REQ-023 The minimum spacing between grants SHALL be HOLD_CYCLES+GAP_CYCLES+1 cycles.
REQ-024 CLEAR=1 SHALL override all other inputs at that edge: next state IDLE, DOT_EN=0, DOT_DIGIT=0, OWNER=00, counter=0, no GNT or ERR pulse, LAST unchanged.
REQ-025 The captured DOT_DIGIT SHALL remain constant through SHOW regardless of changes on DIGIT_x.
REQ-026 The counter SHALL never wrap; it returns to 0 only on a state change.

Reset
REQ-027 While RESET=1, asynchronously: state=IDLE, counter=0, DOT_DIGIT=0, DOT_EN=0, OWNER=00, BUSY=0, GNT_x=0, ERR_x=0, LAST=B (so A wins the first tie).
REQ-028 A RESET assertion mid-SHOW or mid-GAP SHALL abort immediately, and no grant is pending after release.

Verification (HOLD_CYCLES=8, GAP_CYCLES=2)
REQ-029 Reset release, REQ_A=1 with DIGIT_A=5 -> one-cycle GNT_A, DOT_DIGIT=5, DOT_EN=1 for 8 cycles, then DOT_EN=0 for 2 cycles, BUSY high for 10 cycles.
REQ-030 REQ_A and REQ_B held high, DIGIT_A=1, DIGIT_B=2 -> grants A,B,A,B, spaced 11 cycles apart, with DOT_DIGIT alternating 1,2.
REQ-031 REQ_B=1 with DIGIT_B=12 in IDLE -> ERR_B pulses, no GNT_B, DOT_EN stays 0; with REQ_A=1 and DIGIT_A=3 in the same cycle -> GNT_A and DOT_DIGIT=3.
REQ-032 CLEAR=1 at SHOW counter=4 -> next cycle state IDLE, DOT_EN=0, OWNER=00; a held REQ is granted on the following edge.
REQ-033 RESET pulse during GAP -> all outputs return to reset values asynchronously; after release, a tie grants A.
REQ-034 DIGIT_A changed from 7 to 9 during SHOW -> DOT_DIGIT remains 7 until GAP.
